// File: rtl/hack_pkg.sv
// Shared Hack CPU definitions: instruction field positions, common comp codes
// and the decoded-instruction view used by the control stage.
package hack_pkg;

    localparam int unsigned PC_W     = 15;
    localparam int unsigned DATA_W   = 16;

    localparam int unsigned TYPE_BIT = 15;
    localparam int unsigned A_BIT    = 12;
    localparam int unsigned C_MSB    = 11;
    localparam int unsigned C_LSB    = 6;
    localparam int unsigned D_MSB    = 5;
    localparam int unsigned D_LSB    = 3;
    localparam int unsigned J_MSB    = 2;
    localparam int unsigned J_LSB    = 0;

    localparam logic [5:0] COMP_ZERO   = 6'b101010;
    localparam logic [5:0] COMP_ONE    = 6'b111111;
    localparam logic [5:0] COMP_D      = 6'b001100;
    localparam logic [5:0] COMP_DPLUSA = 6'b000010;

    typedef struct packed {
        logic zx;
        logic nx;
        logic zy;
        logic ny;
        logic f;
        logic no;
    } alu_ctrl_t;

    typedef struct packed {
        logic a;
        logic d;
        logic m;
    } dest_t;

    typedef struct packed {
        logic        is_c;
        logic [14:0] imm;
        logic        a;
        alu_ctrl_t   c;
        dest_t       dst;
        logic [2:0]  j;
    } dec_t;

    function automatic dec_t decode(input logic [DATA_W-1:0] inst);
        dec_t d;
        d.is_c = inst[TYPE_BIT];
        d.imm  = inst[14:0];
        d.a    = inst[A_BIT];
        d.c    = alu_ctrl_t'(inst[C_MSB:C_LSB]);
        d.dst  = dest_t'(inst[D_MSB:D_LSB]);
        d.j    = inst[J_MSB:J_LSB];
        return d;
    endfunction

    // j = {lt, eq, gt}
    function automatic logic jump_cond(input logic [2:0] j, input logic zr, input logic ng);
        return (j[2] & ng) | (j[1] & zr) | (j[0] & ~ng & ~zr);
    endfunction

endpackage

// File: rtl/hack_cpu_ctrl_if.sv
// Bundle between the Hack control stage and its surroundings: ROM fetch,
// the external combinational ALU and the asynchronous-read data RAM.
interface hack_cpu_ctrl_if #(
    parameter int unsigned PC_W = hack_pkg::PC_W
);
    logic [15:0]     instruction;
    logic            inst_valid;
    logic [PC_W-1:0] pc;

    logic [15:0]     alu_x;
    logic [15:0]     alu_y;
    logic            alu_zx;
    logic            alu_nx;
    logic            alu_zy;
    logic            alu_ny;
    logic            alu_f;
    logic            alu_no;
    logic [15:0]     alu_out;
    logic            alu_zr;
    logic            alu_ng;

    logic [15:0]     inM;
    logic [15:0]     outM;
    logic            writeM;
    logic [PC_W-1:0] addressM;

    modport master (
        input  instruction, inst_valid, alu_out, alu_zr, alu_ng, inM,
        output pc, alu_x, alu_y, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no,
               outM, writeM, addressM
    );

    modport slave (
        output instruction, inst_valid, alu_out, alu_zr, alu_ng, inM,
        input  pc, alu_x, alu_y, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no,
               outM, writeM, addressM
    );
endinterface

// File: rtl/hack_pc.sv
// Program counter: synchronous reset, then load, then increment, else hold.
module hack_pc #(
    parameter int unsigned PC_W = hack_pkg::PC_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_i,
    input  logic            inc_i,
    input  logic [PC_W-1:0] load_val_i,
    output logic [PC_W-1:0] pc_o
);
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_val_i;
        end else if (inc_i) begin
            pc_d = pc_q + PC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/hack_cpu_ctrl.sv
// Hack CPU control/register stage: decodes one instruction per valid cycle,
// drives the external ALU and commits results to A, D, RAM and the PC.
module hack_cpu_ctrl #(
    parameter int unsigned PC_W = 15
) (
    input  logic             clk,
    input  logic             reset,
    hack_cpu_ctrl_if.master  bus
);
    import hack_pkg::*;

    dec_t            dec;
    alu_ctrl_t       ctrl;
    logic            take_jump;
    logic [15:0]     a_q;
    logic [15:0]     a_d;
    logic [15:0]     d_q;
    logic [15:0]     d_d;
    logic            pc_load;
    logic            pc_inc;
    logic [PC_W-1:0] pc_q;

    assign dec  = decode(bus.instruction);
    assign ctrl = dec.is_c ? dec.c : alu_ctrl_t'(6'b0);

    assign bus.alu_x  = d_q;
    assign bus.alu_y  = dec.a ? bus.inM : a_q;
    assign bus.alu_zx = ctrl.zx;
    assign bus.alu_nx = ctrl.nx;
    assign bus.alu_zy = ctrl.zy;
    assign bus.alu_ny = ctrl.ny;
    assign bus.alu_f  = ctrl.f;
    assign bus.alu_no = ctrl.no;

    // Address and jump target both use A as it stood before this instruction.
    assign bus.outM     = bus.alu_out;
    assign bus.addressM = a_q[PC_W-1:0];
    assign bus.writeM   = dec.is_c & dec.dst.m & bus.inst_valid & ~reset;
    assign bus.pc       = pc_q;

    assign take_jump = dec.is_c & jump_cond(dec.j, bus.alu_zr, bus.alu_ng);

    always_comb begin
        a_d     = a_q;
        d_d     = d_q;
        pc_load = 1'b0;
        pc_inc  = 1'b0;
        if (bus.inst_valid) begin
            if (!dec.is_c) begin
                a_d = {1'b0, dec.imm};
            end else begin
                if (dec.dst.a) a_d = bus.alu_out;
                if (dec.dst.d) d_d = bus.alu_out;
            end
            pc_load = take_jump;
            pc_inc  = ~take_jump;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q <= '0;
            d_q <= '0;
        end else begin
            a_q <= a_d;
            d_q <= d_d;
        end
    end

    hack_pc #(
        .PC_W (PC_W)
    ) u_pc (
        .clk        (clk),
        .reset      (reset),
        .load_i     (pc_load),
        .inc_i      (pc_inc),
        .load_val_i (a_q[PC_W-1:0]),
        .pc_o       (pc_q)
    );

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// Directed bench for hack_cpu_ctrl: a behavioural Hack ALU and a small RAM
// surround the DUT; each table row is one instruction with hand-derived results.
module tb_hack_cpu_ctrl;
    import hack_pkg::*;

    logic clk;
    logic reset;
    logic ram_clr;
    logic [15:0] ram [0:63];

    int n_checks;
    int n_errors;

    hack_cpu_ctrl_if bus ();

    hack_cpu_ctrl #(.PC_W(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] hack_alu(input logic [15:0] x, input logic [15:0] y,
                                             input logic [5:0] c);
        logic [15:0] xa, ya, o;
        xa = c[5] ? 16'h0000 : x;
        xa = c[4] ? ~xa : xa;
        ya = c[3] ? 16'h0000 : y;
        ya = c[2] ? ~ya : ya;
        o  = c[1] ? (xa + ya) : (xa & ya);
        return c[0] ? ~o : o;
    endfunction

    assign bus.alu_out = hack_alu(bus.alu_x, bus.alu_y,
        {bus.alu_zx, bus.alu_nx, bus.alu_zy, bus.alu_ny, bus.alu_f, bus.alu_no});
    assign bus.alu_zr  = (bus.alu_out == 16'h0000);
    assign bus.alu_ng  = bus.alu_out[15];
    assign bus.inM     = ram[bus.addressM[5:0]];

    always_ff @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 64; i++) ram[i] <= 16'h0000;
        end else if (bus.writeM) begin
            ram[bus.addressM[5:0]] <= bus.outM;
        end
    end

    typedef struct {
        logic        rst;
        logic        vld;
        logic [15:0] inst;
        logic        chk_mem;
        logic        wm;
        logic [14:0] addr;
        logic [15:0] outm;
        logic [5:0]  ctrl;
        logic [14:0] pc;
        logic [15:0] a;
        logic [15:0] d;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs [NV];

    task automatic check(input string name, input int idx, input logic [15:0] act,
                         input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    // Park the bus on a stalled A-instruction so alu_y shows A and alu_x shows D.
    task automatic peek_state(input int idx, input logic [14:0] pc_e,
                              input logic [15:0] a_e, input logic [15:0] d_e);
        reset = 1'b0;
        bus.inst_valid  = 1'b0;
        bus.instruction = 16'h0000;
        #1;
        check("pc", idx, 16'(bus.pc), 16'(pc_e));
        check("A",  idx, bus.alu_y, a_e);
        check("D",  idx, bus.alu_x, d_e);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        @(negedge clk);
        reset           = v.rst;
        bus.inst_valid  = v.vld;
        bus.instruction = v.inst;
        #1;
        check("writeM", idx, 16'(bus.writeM), 16'(v.wm));
        check("ctrl", idx,
              16'({bus.alu_zx, bus.alu_nx, bus.alu_zy, bus.alu_ny, bus.alu_f, bus.alu_no}),
              16'(v.ctrl));
        if (v.chk_mem) begin
            check("addressM", idx, 16'(bus.addressM), 16'(v.addr));
            check("outM", idx, bus.outM, v.outm);
        end
        @(posedge clk);
        #1;
        ram_clr = 1'b0;
        peek_state(idx, v.pc, v.a, v.d);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        ram_clr  = 1'b1;
        reset    = 1'b1;
        bus.inst_valid  = 1'b0;
        bus.instruction = 16'h0000;

        //          rst   vld   inst      mem   wm    addr      outM      ctrl         pc        A         D
        vecs[0]  = '{1'b1, 1'b1, 16'hE308, 1'b0, 1'b0, 15'h0000, 16'h0000, COMP_D,      15'h0000, 16'h0000, 16'h0000};
        vecs[1]  = '{1'b0, 1'b1, 16'h0005, 1'b1, 1'b0, 15'h0000, 16'h0000, 6'b000000,   15'h0001, 16'h0005, 16'h0000};
        vecs[2]  = '{1'b0, 1'b1, 16'hEDD0, 1'b1, 1'b0, 15'h0005, 16'h0006, 6'b110111,   15'h0002, 16'h0005, 16'h0006};
        vecs[3]  = '{1'b0, 1'b1, 16'hE308, 1'b1, 1'b1, 15'h0005, 16'h0006, COMP_D,      15'h0003, 16'h0005, 16'h0006};
        vecs[4]  = '{1'b0, 1'b1, 16'h0010, 1'b1, 1'b0, 15'h0005, 16'h0004, 6'b000000,   15'h0004, 16'h0010, 16'h0006};
        vecs[5]  = '{1'b0, 1'b1, 16'hE301, 1'b1, 1'b0, 15'h0010, 16'h0006, COMP_D,      15'h0010, 16'h0010, 16'h0006};
        vecs[6]  = '{1'b0, 1'b1, 16'hEA90, 1'b1, 1'b0, 15'h0010, 16'h0000, COMP_ZERO,   15'h0011, 16'h0010, 16'h0000};
        vecs[7]  = '{1'b0, 1'b1, 16'hE301, 1'b1, 1'b0, 15'h0010, 16'h0000, COMP_D,      15'h0012, 16'h0010, 16'h0000};
        vecs[8]  = '{1'b0, 1'b1, 16'h0020, 1'b1, 1'b0, 15'h0010, 16'h0000, 6'b000000,   15'h0013, 16'h0020, 16'h0000};
        vecs[9]  = '{1'b0, 1'b1, 16'hEEAF, 1'b1, 1'b1, 15'h0020, 16'hFFFF, 6'b111010,   15'h0020, 16'hFFFF, 16'h0000};
        vecs[10] = '{1'b0, 1'b0, 16'hE308, 1'b1, 1'b0, 15'h7FFF, 16'h0000, COMP_D,      15'h0020, 16'hFFFF, 16'h0000};
        vecs[11] = '{1'b0, 1'b0, 16'hE308, 1'b1, 1'b0, 15'h7FFF, 16'h0000, COMP_D,      15'h0020, 16'hFFFF, 16'h0000};
        vecs[12] = '{1'b0, 1'b0, 16'hE308, 1'b1, 1'b0, 15'h7FFF, 16'h0000, COMP_D,      15'h0020, 16'hFFFF, 16'h0000};
        vecs[13] = '{1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b0, 15'h7FFF, 16'h0000, 6'b000000,   15'h0021, 16'h7FFF, 16'h0000};
        vecs[14] = '{1'b0, 1'b1, 16'hEA87, 1'b1, 1'b0, 15'h7FFF, 16'h0000, COMP_ZERO,   15'h7FFF, 16'h7FFF, 16'h0000};
        vecs[15] = '{1'b0, 1'b1, 16'h0003, 1'b1, 1'b0, 15'h7FFF, 16'h0000, 6'b000000,   15'h0000, 16'h0003, 16'h0000};
        vecs[16] = '{1'b0, 1'b1, 16'hEDD0, 1'b1, 1'b0, 15'h0003, 16'h0004, 6'b110111,   15'h0001, 16'h0003, 16'h0004};
        vecs[17] = '{1'b1, 1'b1, 16'hE308, 1'b1, 1'b0, 15'h0003, 16'h0004, COMP_D,      15'h0000, 16'h0000, 16'h0000};
        vecs[18] = '{1'b0, 1'b1, 16'h0007, 1'b1, 1'b0, 15'h0000, 16'h0000, 6'b000000,   15'h0001, 16'h0007, 16'h0000};
        vecs[19] = '{1'b0, 1'b1, 16'h0005, 1'b1, 1'b0, 15'h0007, 16'h0000, 6'b000000,   15'h0002, 16'h0005, 16'h0000};
        vecs[20] = '{1'b0, 1'b1, 16'hFC10, 1'b1, 1'b0, 15'h0005, 16'h0006, 6'b110000,   15'h0003, 16'h0005, 16'h0006};
        vecs[21] = '{1'b0, 1'b1, 16'hE304, 1'b1, 1'b0, 15'h0005, 16'h0006, COMP_D,      15'h0004, 16'h0005, 16'h0006};
        vecs[22] = '{1'b0, 1'b1, 16'hE302, 1'b1, 1'b0, 15'h0005, 16'h0006, COMP_D,      15'h0005, 16'h0005, 16'h0006};
        vecs[23] = '{1'b0, 1'b1, 16'hE090, 1'b1, 1'b0, 15'h0005, 16'h000B, COMP_DPLUSA, 15'h0006, 16'h0005, 16'h000B};
        vecs[24] = '{1'b0, 1'b1, 16'hEFD0, 1'b1, 1'b0, 15'h0005, 16'h0001, COMP_ONE,    15'h0007, 16'h0005, 16'h0001};

        for (int i = 0; i < NV; i++) begin
            run_vec(i, vecs[i]);
        end

        // RAM contents: committed stores landed, the store under reset did not.
        check("ram5",  100, ram[5],  16'h0006);
        check("ram32", 101, ram[32], 16'hFFFF);
        check("ram3",  102, ram[3],  16'h0000);

        // A-instruction with bits 11:6 set must still present all-zero ALU controls.
        @(negedge clk);
        bus.inst_valid  = 1'b1;
        bus.instruction = 16'h0FC0;
        #1;
        check("a_inst_ctrl", 103,
              16'({bus.alu_zx, bus.alu_nx, bus.alu_zy, bus.alu_ny, bus.alu_f, bus.alu_no}),
              16'h0000);
        @(posedge clk);
        #1;
        peek_state(104, 15'h0008, 16'h0FC0, 16'h0001);

        // Reset with an a=1 store in flight: alu_y follows inM, no write, state clears.
        @(negedge clk);
        bus.instruction = 16'h0005;
        bus.inst_valid  = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        reset           = 1'b1;
        bus.inst_valid  = 1'b1;
        bus.instruction = 16'hFC18;
        #1;
        check("rst_writeM", 105, 16'(bus.writeM), 16'h0000);
        check("rst_alu_y",  106, bus.alu_y, 16'h0006);
        @(posedge clk);
        #1;
        peek_state(107, 15'h0000, 16'h0000, 16'h0000);

        // Fetch resumes from address 0 right after reset drops.
        @(negedge clk);
        bus.inst_valid  = 1'b1;
        bus.instruction = 16'h0009;
        #1;
        check("resume_pc0", 108, 16'(bus.pc), 16'h0000);
        @(posedge clk);
        #1;
        peek_state(109, 15'h0001, 16'h0009, 16'h0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
